scheduler: RTL and testbench



---
 rtl/scheduler.sv | 154 +++++++++++++++
 tb/tb_scheduler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scheduler.sv
// rtl/scheduler.sv - CSR sparse block to dense per-row scatter scheduler
module scheduler #(
  parameter int NUM_OF_COLS     = 5,
  parameter int NUM_OF_ROWS     = 5,
  parameter int ROW_LEN_WIDTH   = 8,
  parameter int INDEX_WIDTH     = 8,
  parameter int COL_IDX_WIDTH   = 8,
  parameter int VALUE_WIDTH     = 8,
  parameter int NODE_INFO_WIDTH = ROW_LEN_WIDTH + INDEX_WIDTH + 1,
  parameter int COL_INDEX_SIZE  = 8,
  parameter int VALUE_SIZE      = 8,
  parameter int NODE_INFO_SIZE  = 5,
  parameter int ROW_INFO_WIDTH  = ROW_LEN_WIDTH + 1
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          sched_valid,
  output logic                                          sched_ready,
  input  logic [COL_INDEX_SIZE*COL_IDX_WIDTH-1:0]       col_idx_i,
  input  logic [VALUE_SIZE*VALUE_WIDTH-1:0]             value_i,
  input  logic [NODE_INFO_SIZE*NODE_INFO_WIDTH-1:0]     node_info_i,
  output logic [NUM_OF_ROWS*NUM_OF_COLS*COL_IDX_WIDTH-1:0] row_col_idx,
  output logic [NUM_OF_ROWS*NUM_OF_COLS*VALUE_WIDTH-1:0]   row_value,
  output logic [NUM_OF_ROWS*ROW_INFO_WIDTH-1:0]            row_info
);

  localparam int R_W  = (NUM_OF_ROWS > 1) ? $clog2(NUM_OF_ROWS) : 1;
  localparam int CI_W = COL_INDEX_SIZE * COL_IDX_WIDTH;
  localparam int VA_W = VALUE_SIZE * VALUE_WIDTH;
  localparam int NI_W = NODE_INFO_SIZE * NODE_INFO_WIDTH;
  localparam int RC_W = NUM_OF_ROWS * NUM_OF_COLS * COL_IDX_WIDTH;
  localparam int RV_W = NUM_OF_ROWS * NUM_OF_COLS * VALUE_WIDTH;
  localparam int RI_W = NUM_OF_ROWS * ROW_INFO_WIDTH;

  typedef enum logic {IDLE, SCATTER} state_t;

  state_t              state_q, state_d;
  logic [R_W-1:0]      r_q, r_d;
  logic [CI_W-1:0]     col_q, col_d;
  logic [VA_W-1:0]     val_q, val_d;
  logic [NI_W-1:0]     node_q, node_d;
  logic [RC_W-1:0]     row_col_q, row_col_d;
  logic [RV_W-1:0]     row_val_q, row_val_d;
  logic [RI_W-1:0]     row_info_q, row_info_d;

  logic [NODE_INFO_WIDTH-1:0] cur_node;
  logic [INDEX_WIDTH-1:0]     cur_start;
  logic [ROW_LEN_WIDTH-1:0]   cur_len;
  logic                       cur_flag;
  logic [INDEX_WIDTH:0]       addr;
  logic [COL_IDX_WIDTH-1:0]   sel_col;
  logic [VALUE_WIDTH-1:0]     sel_val;

  assign row_col_idx = row_col_q;
  assign row_value   = row_val_q;
  assign row_info    = row_info_q;

  // Next-state: capture and clear on accept, then scatter one row per cycle
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    col_d       = col_q;
    val_d       = val_q;
    node_d      = node_q;
    row_col_d   = row_col_q;
    row_val_d   = row_val_q;
    row_info_d  = row_info_q;
    sched_ready = 1'b0;
    cur_node    = '0;
    cur_start   = '0;
    cur_len     = '0;
    cur_flag    = 1'b0;
    addr        = '0;
    sel_col     = '0;
    sel_val     = '0;
    case (state_q)
      IDLE: begin
        sched_ready = 1'b1;
        if (sched_valid) begin
          col_d      = col_idx_i;
          val_d      = value_i;
          node_d     = node_info_i;
          row_col_d  = '0;
          row_val_d  = '0;
          row_info_d = '0;
          r_d        = '0;
          state_d    = SCATTER;
        end
      end
      SCATTER: begin
        for (int n = 0; n < NUM_OF_ROWS; n++) begin
          if (r_q == R_W'(n)) cur_node = node_q[n*NODE_INFO_WIDTH +: NODE_INFO_WIDTH];
        end
        cur_start = cur_node[NODE_INFO_WIDTH-1 -: INDEX_WIDTH];
        cur_len   = cur_node[ROW_LEN_WIDTH:1];
        cur_flag  = cur_node[0];
        for (int c = 0; c < NUM_OF_COLS; c++) begin
          // Widened by one bit so start+offset never wraps into a valid slot
          addr    = {1'b0, cur_start} + (INDEX_WIDTH+1)'(c);
          sel_col = '0;
          sel_val = '0;
          if ((32'(c) < 32'(cur_len)) && (addr < (INDEX_WIDTH+1)'(COL_INDEX_SIZE))) begin
            for (int k = 0; k < COL_INDEX_SIZE; k++) begin
              if (addr == (INDEX_WIDTH+1)'(k)) begin
                sel_col = col_q[k*COL_IDX_WIDTH +: COL_IDX_WIDTH];
                sel_val = val_q[k*VALUE_WIDTH +: VALUE_WIDTH];
              end
            end
          end
          for (int n = 0; n < NUM_OF_ROWS; n++) begin
            if (r_q == R_W'(n)) begin
              row_col_d[(n*NUM_OF_COLS+c)*COL_IDX_WIDTH +: COL_IDX_WIDTH] = sel_col;
              row_val_d[(n*NUM_OF_COLS+c)*VALUE_WIDTH +: VALUE_WIDTH]     = sel_val;
            end
          end
        end
        for (int n = 0; n < NUM_OF_ROWS; n++) begin
          if (r_q == R_W'(n)) row_info_d[n*ROW_INFO_WIDTH +: ROW_INFO_WIDTH] = {cur_len, cur_flag};
        end
        if (r_q == R_W'(NUM_OF_ROWS-1)) begin
          r_d     = '0;
          state_d = IDLE;
        end else begin
          r_d = r_q + R_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any job and clears all outputs immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      r_q        <= '0;
      col_q      <= '0;
      val_q      <= '0;
      node_q     <= '0;
      row_col_q  <= '0;
      row_val_q  <= '0;
      row_info_q <= '0;
    end else begin
      state_q    <= state_d;
      r_q        <= r_d;
      col_q      <= col_d;
      val_q      <= val_d;
      node_q     <= node_d;
      row_col_q  <= row_col_d;
      row_val_q  <= row_val_d;
      row_info_q <= row_info_d;
    end
  end

endmodule

// File: tb/tb_scheduler.sv
// tb/tb_scheduler.sv - scoreboard bench for the sparse-row scheduler
module tb_scheduler;

  localparam int NC = 5, NR = 5, CS = 8, NIW = 17, RIW = 9;
  localparam int RC_W = NR*NC*8, RI_W = NR*RIW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sched_valid = 1'b0;
  logic sched_ready;
  logic [CS*8-1:0]   col_idx_i = '0;
  logic [CS*8-1:0]   value_i = '0;
  logic [NR*NIW-1:0] node_info_i = '0;
  logic [RC_W-1:0]   row_col_idx;
  logic [RC_W-1:0]   row_value;
  logic [RI_W-1:0]   row_info;

  typedef struct {
    logic [RC_W-1:0] col;
    logic [RC_W-1:0] val;
    logic [RI_W-1:0] info;
  } exp_t;

  exp_t sb[$];
  int col_a[CS], val_a[CS], st[NR], ln[NR], fl[NR];
  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  scheduler dut (
    .clk(clk), .rst_n(rst_n), .sched_valid(sched_valid), .sched_ready(sched_ready),
    .col_idx_i(col_idx_i), .value_i(value_i), .node_info_i(node_info_i),
    .row_col_idx(row_col_idx), .row_value(row_value), .row_info(row_info)
  );

  function automatic exp_t model();
    exp_t e;
    int idx;
    e.col = '0; e.val = '0; e.info = '0;
    for (int r = 0; r < NR; r++) begin
      for (int c = 0; c < NC; c++) begin
        idx = st[r] + c;
        if (c < ln[r] && idx < CS) begin
          e.col[(r*NC+c)*8 +: 8] = col_a[idx][7:0];
          e.val[(r*NC+c)*8 +: 8] = val_a[idx][7:0];
        end
      end
      e.info[r*RIW +: RIW] = {ln[r][7:0], fl[r][0]};
    end
    return e;
  endfunction

  task automatic load_basic();
    int c0[CS] = '{0,4,2,4,1,3,2,4};
    int v0[CS] = '{2,9,7,8,6,5,3,1};
    int s0[NR] = '{0,2,4,6,7};
    int l0[NR] = '{2,2,2,1,1};
    for (int i = 0; i < CS; i++) begin col_a[i] = c0[i]; val_a[i] = v0[i]; end
    for (int r = 0; r < NR; r++) begin st[r] = s0[r]; ln[r] = l0[r]; fl[r] = 0; end
  endtask

  task automatic load_alt();
    int s1[NR] = '{1,3,5,0,2};
    int l1[NR] = '{3,1,2,5,4};
    int f1[NR] = '{1,0,1,1,0};
    for (int i = 0; i < CS; i++) begin col_a[i] = i + 1; val_a[i] = 10 + i; end
    for (int r = 0; r < NR; r++) begin st[r] = s1[r]; ln[r] = l1[r]; fl[r] = f1[r]; end
  endtask

  task automatic apply_inputs();
    for (int i = 0; i < CS; i++) begin
      col_idx_i[i*8 +: 8] = col_a[i][7:0];
      value_i[i*8 +: 8]   = val_a[i][7:0];
    end
    for (int r = 0; r < NR; r++) node_info_i[r*NIW +: NIW] = {st[r][7:0], ln[r][7:0], fl[r][0]};
  endtask

  task automatic check_cleared(input string name);
    n_cmp++;
    if (sched_ready !== 1'b0) begin
      n_fail++; $display("FAIL %s_ready got %b want 0", name, sched_ready);
    end
    n_cmp++;
    if (row_col_idx !== '0 || row_value !== '0 || row_info !== '0) begin
      n_fail++; $display("FAIL %s_clear got col=%h val=%h info=%h want 0", name, row_col_idx, row_value, row_info);
    end
  endtask

  task automatic start_job(input string name);
    @(negedge clk);
    apply_inputs();
    sched_valid = 1'b1;
    sb.push_back(model());
    @(negedge clk);
    sched_valid = 1'b0;
    check_cleared(name);
  endtask

  task automatic finish_job(input string name, input int spent);
    int n;
    exp_t e;
    n = spent;
    while (!sched_ready && n < 20) begin @(negedge clk); n++; end
    n_cmp++;
    if (n !== NR) begin
      n_fail++; $display("FAIL %s_latency got %0d cycles want %0d", name, n, NR);
    end
    n_cmp++;
    if (sb.size() == 0) begin
      n_fail++; $display("FAIL %s_sb got empty want entry", name);
    end else begin
      e = sb.pop_front();
      n_cmp++;
      if (row_col_idx !== e.col) begin
        n_fail++; $display("FAIL %s_col got %h want %h", name, row_col_idx, e.col);
      end
      n_cmp++;
      if (row_value !== e.val) begin
        n_fail++; $display("FAIL %s_val got %h want %h", name, row_value, e.val);
      end
      n_cmp++;
      if (row_info !== e.info) begin
        n_fail++; $display("FAIL %s_info got %h want %h", name, row_info, e.info);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sched_ready !== 1'b1 || row_col_idx !== '0 || row_value !== '0 || row_info !== '0) begin
      n_fail++; $display("FAIL reset_hold got ready=%b info=%h want ready=1 all 0", sched_ready, row_info);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sched_ready !== 1'b1 || row_col_idx !== '0 || row_value !== '0 || row_info !== '0) begin
      n_fail++; $display("FAIL reset_release got ready=%b info=%h want ready=1 all 0", sched_ready, row_info);
    end
  endtask

  task automatic test_basic();
    load_basic();
    start_job("basic");
    finish_job("basic", 0);
    n_cmp++;
    if (row_info !== {9'd2, 9'd2, 9'd4, 9'd4, 9'd4}) begin
      n_fail++; $display("FAIL basic_row_info got %h want 4,4,4,2,2", row_info);
    end
    n_cmp++;
    if (row_col_idx[1*8 +: 8] !== 8'd4 || row_col_idx[20*8 +: 8] !== 8'd4 || row_value[15*8 +: 8] !== 8'd3) begin
      n_fail++; $display("FAIL basic_entries got r0c1=%0d r4c0=%0d r3v0=%0d want 4 4 3",
        row_col_idx[1*8 +: 8], row_col_idx[20*8 +: 8], row_value[15*8 +: 8]);
    end
  endtask

  task automatic test_busy();
    load_basic();
    start_job("busy");
    load_alt();
    @(negedge clk); apply_inputs(); sched_valid = 1'b1;
    @(negedge clk);
    @(negedge clk); sched_valid = 1'b0;
    finish_job("busy", 3);
  endtask

  task automatic test_overlong();
    load_basic();
    ln[0] = 7;
    start_job("overlong");
    finish_job("overlong", 0);
    n_cmp++;
    if (row_info[8:0] !== 9'd14 || row_col_idx[4*8 +: 8] !== 8'd1 || row_value[4*8 +: 8] !== 8'd6) begin
      n_fail++; $display("FAIL overlong_row0 got info=%0d c4=%0d v4=%0d want 14 1 6",
        row_info[8:0], row_col_idx[4*8 +: 8], row_value[4*8 +: 8]);
    end
  endtask

  task automatic test_oob();
    load_basic();
    st[1] = 7; ln[1] = 3;
    start_job("oob");
    finish_job("oob", 0);
    n_cmp++;
    if (row_col_idx[5*8 +: 8] !== 8'd4 || row_value[5*8 +: 8] !== 8'd1 ||
        row_col_idx[6*8 +: 32] !== '0 || row_value[6*8 +: 32] !== '0) begin
      n_fail++; $display("FAIL oob_row1 got col=%h val=%h want c0=4 v0=1 rest 0",
        row_col_idx[5*8 +: 40], row_value[5*8 +: 40]);
    end
  endtask

  task automatic test_midreset();
    exp_t e;
    load_basic();
    start_job("midrst");
    @(negedge clk);
    e = sb[sb.size()-1];
    n_cmp++;
    if (row_col_idx[0 +: 40] !== e.col[0 +: 40] || row_col_idx[40 +: 40] !== '0) begin
      n_fail++; $display("FAIL midrst_row0_timing got %h want %h", row_col_idx[0 +: 80], {40'h0, e.col[0 +: 40]});
    end
    @(posedge clk); #1 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (sched_ready !== 1'b1 || row_col_idx !== '0 || row_value !== '0 || row_info !== '0) begin
      n_fail++; $display("FAIL midrst_clear got ready=%b info=%h want ready=1 all 0", sched_ready, row_info);
    end
    void'(sb.pop_back());
    repeat (2) @(negedge clk);
    @(posedge clk); #1 rst_n = 1'b1;
    load_basic();
    start_job("midrst_next");
    finish_job("midrst_next", 0);
  endtask

  task automatic test_back_to_back();
    int n;
    exp_t e;
    load_basic();
    @(negedge clk); apply_inputs(); sched_valid = 1'b1; sb.push_back(model());
    @(negedge clk);
    load_alt(); apply_inputs(); sb.push_back(model());
    n = 0;
    while (!sched_ready && n < 20) begin @(negedge clk); n++; end
    n_cmp++;
    if (n !== NR) begin
      n_fail++; $display("FAIL b2b_latency got %0d want %0d", n, NR);
    end
    e = sb.pop_front();
    n_cmp++;
    if (row_col_idx !== e.col || row_value !== e.val || row_info !== e.info) begin
      n_fail++; $display("FAIL b2b_first got info=%h want %h", row_info, e.info);
    end
    @(negedge clk);
    sched_valid = 1'b0;
    check_cleared("b2b_second");
    finish_job("b2b_second", 0);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_busy();
    test_overlong();
    test_oob();
    test_midreset();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
